// File: rtl/serial_idft_synth.sv
// -----------------------------------------------------------------------------
// serial_idft_synth
//
// Serial inverse DFT. Accepts one frame of FRAME_LENGTH complex spectral bins
// in bin order k = 0..N-1. All N output accumulators update in parallel on
// every accepted bin. The block then streams the real time-domain frame out,
// one sample per cycle:
//   x[n] = sat( (sum_k Xre[k]*cos(2*pi*k*n/N) - Xim[k]*sin(2*pi*k*n/N)) >>> SHIFT )
//
// Ports
//   clk      : clock, rising edge
//   arstn    : asynchronous active-low reset
//   w_re[m]  : cos(2*pi*m/N), Q1.(W_WIDTH-2); static during a frame
//   w_im[m]  : sin(2*pi*m/N), Q1.(W_WIDTH-2); static during a frame
//   valid_i  : bin present on re_i/im_i
//   ready_o  : block accepts a bin this cycle (high while accumulating)
//   re_i     : signed real part of bin k
//   im_i     : signed imaginary part of bin k
//   x_o      : signed time sample n (holds its value when valid_o = 0)
//   valid_o  : x_o valid this cycle
//   last_o   : marks sample n = N-1
// -----------------------------------------------------------------------------
module serial_idft_synth #(
  parameter int W_WIDTH      = 16,
  parameter int X_WIDTH      = 16,
  parameter int S_WIDTH      = 40,
  parameter int O_WIDTH      = 16,
  parameter int SHIFT        = 14,
  parameter int FRAME_LENGTH = 4
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic signed [W_WIDTH-1:0] w_re [FRAME_LENGTH],
  input  logic signed [W_WIDTH-1:0] w_im [FRAME_LENGTH],
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [X_WIDTH-1:0] re_i,
  input  logic signed [X_WIDTH-1:0] im_i,
  output logic signed [O_WIDTH-1:0] x_o,
  output logic                      valid_o,
  output logic                      last_o
);

  localparam int N  = FRAME_LENGTH;
  localparam int CW = $clog2(FRAME_LENGTH);
  localparam int PW = X_WIDTH + W_WIDTH + 1;

  // Output clamp limits, expressed at accumulator width.
  localparam logic signed [S_WIDTH-1:0] SAT_MAX =
    {{(S_WIDTH-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [S_WIDTH-1:0] SAT_MIN =
    {{(S_WIDTH-O_WIDTH+1){1'b1}}, {(O_WIDTH-1){1'b0}}};

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CW-1:0]             r_k;
  logic [CW-1:0]             r_dcnt;
  logic [CW-1:0]             r_idx      [N];
  logic signed [S_WIDTH-1:0] r_acc      [N];
  logic [CW-1:0]             w_idx_next [N];
  logic signed [S_WIDTH-1:0] w_acc_next [N];
  logic signed [S_WIDTH-1:0] w_drain_acc;
  logic                      w_accept;
  logic                      w_last_bin;
  logic                      w_last_drain;

  // Arithmetic (floor) shift followed by a clamp into the output range.
  function automatic logic signed [O_WIDTH-1:0] f_sat(
    input logic signed [S_WIDTH-1:0] a
  );
    logic signed [S_WIDTH-1:0] s;
    s = a >>> SHIFT;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[O_WIDTH-1:0];
  endfunction

  assign ready_o      = (r_state == S_ACCUM);
  assign w_accept     = valid_i && ready_o;
  assign w_last_bin   = w_accept && (r_k == CW'(N-1));
  assign w_last_drain = (r_state == S_DRAIN) && (r_dcnt == CW'(N-1));

  // One lane per output sample n. idx[n] tracks (k*n) mod N incrementally,
  // so the twiddle lookup never needs a multiplier.
  for (genvar gn = 0; gn < N; gn++) begin : g_lane
    logic signed [PW-1:0] w_prod_re;
    logic signed [PW-1:0] w_prod_im;
    logic signed [PW-1:0] w_p;
    logic [CW:0]          w_idx_sum;

    assign w_prod_re = PW'(re_i) * PW'(w_re[r_idx[gn]]);
    assign w_prod_im = PW'(im_i) * PW'(w_im[r_idx[gn]]);
    assign w_p       = w_prod_re - w_prod_im;

    // Accumulator overflow wraps; S_WIDTH is sized by the integrator.
    assign w_acc_next[gn] = r_acc[gn] + S_WIDTH'(w_p);

    assign w_idx_sum      = {1'b0, r_idx[gn]} + (CW+1)'(gn);
    assign w_idx_next[gn] = (w_idx_sum >= (CW+1)'(N)) ?
                            CW'(w_idx_sum - (CW+1)'(N)) : CW'(w_idx_sum);
  end

  // Accumulator for the sample to present next during the drain (n + 1).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_drain_acc = r_acc[0];
    for (int i = 0; i < N - 1; i++) begin
      if (r_dcnt == CW'(i)) w_drain_acc = r_acc[i+1];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= S_ACCUM;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM: if (w_last_bin)   w_state_next = S_DRAIN;
      S_DRAIN: if (w_last_drain) w_state_next = S_ACCUM;
      default:                   w_state_next = S_ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. The first sample is loaded straight from the final accumulation
  // so that valid_o rises on the cycle right after the last bin is accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      // NOTE: the accumulator and index arrays are reset explicitly because a
      // reset mid-frame must abandon the partial sums; the arrays are small
      // register banks, not RAM.
      for (int i = 0; i < N; i++) begin
        r_acc[i] <= '0;
        r_idx[i] <= '0;
      end
      r_k     <= '0;
      r_dcnt  <= '0;
      x_o     <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            for (int i = 0; i < N; i++) begin
              r_acc[i] <= w_acc_next[i];
              r_idx[i] <= w_idx_next[i];
            end
            r_k <= r_k + CW'(1);
            if (w_last_bin) begin
              r_k     <= '0;
              r_dcnt  <= '0;
              x_o     <= f_sat(w_acc_next[0]);
              valid_o <= 1'b1;
              last_o  <= 1'b0;
            end
          end
        end

        S_DRAIN: begin
          if (w_last_drain) begin
            // Return to ACCUM with a clean slate for the next frame.
            for (int i = 0; i < N; i++) begin
              r_acc[i] <= '0;
              r_idx[i] <= '0;
            end
            r_k     <= '0;
            r_dcnt  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
          end else begin
            r_dcnt  <= r_dcnt + CW'(1);
            x_o     <= f_sat(w_drain_acc);
            valid_o <= 1'b1;
            last_o  <= (r_dcnt == CW'(N-2));
          end
        end

        default: begin
          valid_o <= 1'b0;
          last_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_idft_synth.sv
// -----------------------------------------------------------------------------
// tb_serial_idft_synth
//
// Directed bench for serial_idft_synth with N = 4, W_WIDTH = 16, SHIFT = 14.
// Two instances share all inputs: u_dut (O_WIDTH = 16) and u_dut8
// (O_WIDTH = 8) so that clamping is visible alongside the unclamped result.
// -----------------------------------------------------------------------------
module tb_serial_idft_synth;

  localparam int N = 4;

  logic               clk;
  logic               arstn;
  logic signed [15:0] tw_re [N];
  logic signed [15:0] tw_im [N];
  logic               valid_i;
  logic signed [15:0] re_i;
  logic signed [15:0] im_i;

  logic               ready_o;
  logic signed [15:0] x_o;
  logic               valid_o;
  logic               last_o;

  logic               ready_o8;
  logic signed [7:0]  x_o8;
  logic               valid_o8;
  logic               last_o8;

  int checks = 0;
  int errors = 0;

  int v_re   [N];
  int v_im   [N];
  int v_exp  [N];
  int v_exp8 [N];

  serial_idft_synth #(
    .W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(40), .O_WIDTH(16),
    .SHIFT(14), .FRAME_LENGTH(N)
  ) u_dut (
    .clk(clk), .arstn(arstn), .w_re(tw_re), .w_im(tw_im),
    .valid_i(valid_i), .ready_o(ready_o), .re_i(re_i), .im_i(im_i),
    .x_o(x_o), .valid_o(valid_o), .last_o(last_o)
  );

  serial_idft_synth #(
    .W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(40), .O_WIDTH(8),
    .SHIFT(14), .FRAME_LENGTH(N)
  ) u_dut8 (
    .clk(clk), .arstn(arstn), .w_re(tw_re), .w_im(tw_im),
    .valid_i(valid_i), .ready_o(ready_o8), .re_i(re_i), .im_i(im_i),
    .x_o(x_o8), .valid_o(valid_o8), .last_o(last_o8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sends v_re/v_im as one frame (optionally with idle gaps and with junk held
  // on the input during the drain), then checks the 4 drained samples of both
  // instances against v_exp / v_exp8. Called and returns 1 time unit after a
  // rising edge.
  task automatic run_frame(input string tag, input bit gaps, input bit junk);
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        valid_i = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
      end
      check({tag, " ready_before_bin"}, 32'(ready_o), 32'd1);
      check({tag, " no_early_valid"},   32'(valid_o | valid_o8), 32'd0);
      valid_i = 1'b1;
      re_i    = 16'(v_re[k]);
      im_i    = 16'(v_im[k]);
      @(posedge clk);
      #1;
    end
    if (junk) begin
      valid_i = 1'b1;
      re_i    = 16'sd1234;
      im_i    = -16'sd77;
    end else begin
      valid_i = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check({tag, " valid"}, 32'(valid_o), 32'd1);
      check({tag, " x"},     32'(x_o),     32'(v_exp[i]));
      check({tag, " last"},  32'(last_o),  32'(i == N - 1));
      check({tag, " ready_drain"}, 32'(ready_o), 32'd0);
      check({tag, " x8"},    32'(x_o8),    32'(v_exp8[i]));
      check({tag, " valid8"}, 32'(valid_o8), 32'd1);
    end
    @(negedge clk);
    check({tag, " valid_after"}, 32'(valid_o), 32'd0);
    check({tag, " last_after"},  32'(last_o),  32'd0);
    check({tag, " ready_after"}, 32'(ready_o), 32'd1);
    check({tag, " x_hold"},      32'(x_o),     32'(v_exp[N-1]));
    valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tw_re   = '{16'sd16384, 16'sd0, -16'sd16384, 16'sd0};
    tw_im   = '{16'sd0, 16'sd16384, 16'sd0, -16'sd16384};
    arstn   = 1'b0;
    valid_i = 1'b0;
    re_i    = '0;
    im_i    = '0;

    // Reset state.
    #12;
    check("rst ready", 32'(ready_o), 32'd1);
    check("rst valid", 32'(valid_o), 32'd0);
    check("rst last",  32'(last_o),  32'd0);
    check("rst x",     32'(x_o),     32'd0);
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // DC bin.
    v_re = '{4, 0, 0, 0};   v_im = '{0, 0, 0, 0};
    v_exp = '{4, 4, 4, 4};  v_exp8 = '{4, 4, 4, 4};
    run_frame("dc", 1'b0, 1'b0);

    // Cosine at bin 1.
    v_re = '{0, 4, 0, 0};   v_im = '{0, 0, 0, 0};
    v_exp = '{4, 0, -4, 0}; v_exp8 = '{4, 0, -4, 0};
    run_frame("cos", 1'b0, 1'b0);

    // Imaginary bin 1 gives a negated sine.
    v_re = '{0, 0, 0, 0};   v_im = '{0, 4, 0, 0};
    v_exp = '{0, -4, 0, 4}; v_exp8 = '{0, -4, 0, 4};
    run_frame("imag", 1'b0, 1'b0);

    // Positive saturation on the 8-bit instance.
    v_re = '{100, 0, 100, 0};   v_im = '{0, 0, 0, 0};
    v_exp = '{200, 0, 200, 0};  v_exp8 = '{127, 0, 127, 0};
    run_frame("sat_pos", 1'b0, 1'b0);

    // Negative saturation on the 8-bit instance.
    v_re = '{-100, 0, -100, 0}; v_im = '{0, 0, 0, 0};
    v_exp = '{-200, 0, -200, 0}; v_exp8 = '{-128, 0, -128, 0};
    run_frame("sat_neg", 1'b0, 1'b0);

    // Gaps between bins, junk held on the input during the drain.
    v_re = '{0, 4, 0, 0};   v_im = '{0, 0, 0, 0};
    v_exp = '{4, 0, -4, 0}; v_exp8 = '{4, 0, -4, 0};
    run_frame("gaps", 1'b1, 1'b1);

    // Junk must not have leaked into the next frame.
    v_re = '{4, 0, 0, 0};   v_im = '{0, 0, 0, 0};
    v_exp = '{4, 4, 4, 4};  v_exp8 = '{4, 4, 4, 4};
    run_frame("after_junk", 1'b0, 1'b0);

    // Reset after two accepted bins abandons the frame.
    valid_i = 1'b1;
    re_i    = 16'sd9;
    im_i    = 16'sd5;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    arstn   = 1'b0;
    #1;
    check("midrst valid", 32'(valid_o), 32'd0);
    check("midrst ready", 32'(ready_o), 32'd1);
    check("midrst x",     32'(x_o),     32'd0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    v_re = '{4, 0, 0, 0};   v_im = '{0, 0, 0, 0};
    v_exp = '{4, 4, 4, 4};  v_exp8 = '{4, 4, 4, 4};
    run_frame("after_rst", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
